grey_reader: RTL and testbench
==============================

# grey_reader

Readback sequencer for the `grey` 12-digit Johnson-code decade counter. On request it walks the counter's `i_sel` digit select from ones (0) to hundred-billions (11). It samples the 8-bit `o_cnt` output for each digit and decodes each 5-bit Johnson code to BCD. It then presents the whole 48-bit BCD snapshot atomically with a one-cycle valid strobe. It sits between the counter and whatever logic, such as a display driver or host interface, needs a coherent decimal value.

## Interface
- `SEL_LAT`, default 1: cycles from `o_sel` change to valid data on `i_cnt`. Legal range 0..7.
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  read request; sampled only in IDLE.
- `i_cnt`  in  8  counter `o_cnt`; bits [4:0] = Johnson code of the selected digit, bits [7:5] ignored.
- `o_sel`  out  8  digit select to the counter `i_sel`; bits [7:4] always 0.
- `o_busy`  out  1  frame in progress.
- `o_valid`  out  1  one-cycle strobe; `o_bcd` and `o_err` updated this cycle.
- `o_bcd`  out  48  digit n in bits [4n+3:4n]; n=0 is ones, n=11 is hundred-billions.
- `o_err`  out  1  frame contained an invalid Johnson code (see Configuration).

## Operation
- Johnson decode, 5-bit code to digit:
  - 00000→0, 00001→1, 00011→2, 00111→3, 01111→4
  - 11111→5, 11110→6, 11100→7, 11000→8, 10000→9
  - The other 22 codes are invalid.
- States are IDLE, SCAN and DONE.
- IDLE with `i_start`=1:
  - `o_sel` is set to 0 and digit index `idx` is set to 0.
  - The wait counter `wc` is set to SEL_LAT, the error accumulator is cleared, and `o_busy` is set to 1.
  - The state moves to SCAN.
- SCAN with `wc`≠0: `wc` decrements by 1.
- SCAN with `wc`=0:
  - The decoded `i_cnt[4:0]` is written into shadow digit `idx`.
  - For idx<11: `idx`, and with it `o_sel`, increments and `wc` is set to SEL_LAT.
  - For idx=11: the state moves to DONE.
- DONE:
  - The shadow register is copied to `o_bcd` and the accumulator to `o_err`.
  - `o_valid` is 1 for this single cycle and `o_busy` goes to 0.
  - The state moves to IDLE.
- `i_start` in SCAN or DONE is ignored; it is not queued.
- `o_bcd` and `o_err` hold their values between frames and change only in the DONE cycle. A partially scanned frame is never visible on them.
- `o_sel` holds its last value (11) in IDLE after a frame.

## Timing
- Reset state: IDLE, `o_sel`=0, `o_busy`=0, `o_valid`=0, `o_bcd`=0, `o_err`=0, and shadow, `idx` and `wc` all 0.
- All outputs are registered.
- Each digit takes SEL_LAT+1 cycles.
- With `i_start` sampled at edge 0:
  - Digit n is sampled at edge (n+1)(SEL_LAT+1).
  - `o_valid` is high in the cycle after edge 12(SEL_LAT+1)+1, i.e. 25 cycles for SEL_LAT=1 and 13 cycles for SEL_LAT=0.
- SEL_LAT=0: `i_cnt` is sampled in the same cycle `o_sel` presents the index, so the counter readout must be combinational.
- The earliest next start is the edge after the `o_valid` cycle, giving a frame period of 12(SEL_LAT+1)+2 cycles.
- Reset mid-frame: the frame is abandoned immediately, all outputs return to their reset values, and no `o_valid` is produced.
- The counter may advance during a scan. Digits are taken at their sample instants, and no coherence across digits is guaranteed beyond that.

## Configuration
- `GREY_READER_CHECK_EN` defined:
  - An invalid code stores 4'hF in that digit and sets the error accumulator.
  - `o_err` reports the accumulator at DONE and is cleared at the next accepted start.
- Not defined:
  - Invalid codes store 4'h0.
  - `o_err` is tied to 0 and the accumulator logic is absent.

## Test plan
- Reset then idle: `o_sel`=0, `o_valid`=0, `o_bcd`=0 for 50 cycles with `i_start` low.
- Counter init 123456789012, SEL_LAT=1, pulse `i_start`:
  - `o_sel` steps 0..11, changing every 2 cycles.
  - `o_valid` strobes 25 cycles later with `o_bcd`=48'h123456789012 and `o_err`=0.
- SEL_LAT=0 model, all digits 9 (code 10000): `o_valid` arrives 13 cycles after start with `o_bcd`=48'h999999999999.
- With the macro defined, force `i_cnt`=5'b01010 only while `o_sel`=3:
  - Digit 3 reads F and `o_err`=1.
  - The next clean frame gives `o_err`=0.
- Hold `i_start` high for a full frame plus one cycle: exactly one `o_valid` per frame, and no start is accepted while `o_busy`=1.
- Assert `i_rst` at cycle 10 of a frame:
  - Outputs go to reset values asynchronously and no `o_valid` occurs.
  - A new start yields a correct frame.

Source files
------------

// File: rtl/grey_reader.sv
// grey_reader: readback sequencer for the 12-digit Johnson-code decade counter.
//   Walks the digit select 0..11, waits SEL_LAT cycles per digit, decodes each
//   5-bit Johnson code to BCD and publishes the full 48-bit snapshot atomically.
//   Latency 12*(SEL_LAT+1)+1 cycles from accepted start to o_valid; starts
//   outside IDLE are dropped, not queued.
// Ports:
//   i_clk, i_rst (async, active-high)  clock and reset
//   i_start                            read request, honoured only in IDLE
//   i_cnt[7:0]                         counter readout, [4:0] = Johnson code
//   o_sel[7:0]                         digit select to the counter, [7:4] = 0
//   o_busy / o_valid                   frame in progress / one-cycle result strobe
//   o_bcd[47:0] / o_err                snapshot (digit n at [4n+3:4n]) / bad-code flag
// Option: define GREY_READER_CHECK_EN to mark invalid codes as 4'hF and report
//   them on o_err; otherwise invalid codes read as 0 and o_err is tied low.
module grey_reader #(
  parameter int unsigned SEL_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_cnt,
  output logic [7:0]  o_sel,
  output logic        o_busy,
  output logic        o_valid,
  output logic [47:0] o_bcd,
  output logic        o_err
);

  localparam logic [2:0] LAT      = 3'(SEL_LAT);
  localparam logic [3:0] LAST_IDX = 4'd11;

`ifdef GREY_READER_CHECK_EN
  localparam logic [3:0] BAD_DIGIT = 4'hF;
`else
  localparam logic [3:0] BAD_DIGIT = 4'h0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  wc_q, wc_d;
  logic [47:0] shadow_q, shadow_d;
  logic [47:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;

  // Upper readout bits carry nothing for this block.
  logic        unused_cnt_hi;
  assign unused_cnt_hi = ^i_cnt[7:5];

  // Johnson decode of the sampled code.
  logic [3:0] dig;
  logic       code_ok;
  always_comb begin
    dig     = 4'h0;
    code_ok = 1'b1;
    case (i_cnt[4:0])
      5'b00000: dig = 4'd0;
      5'b00001: dig = 4'd1;
      5'b00011: dig = 4'd2;
      5'b00111: dig = 4'd3;
      5'b01111: dig = 4'd4;
      5'b11111: dig = 4'd5;
      5'b11110: dig = 4'd6;
      5'b11100: dig = 4'd7;
      5'b11000: dig = 4'd8;
      5'b10000: dig = 4'd9;
      default:  code_ok = 1'b0;
    endcase
  end

`ifdef GREY_READER_CHECK_EN
  logic acc_q, acc_d;
  logic err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wc_d     = wc_q;
    shadow_d = shadow_q;
    bcd_d    = bcd_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
`ifdef GREY_READER_CHECK_EN
    acc_d    = acc_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          idx_d   = 4'd0;
          wc_d    = LAT;
          busy_d  = 1'b1;
          state_d = S_SCAN;
`ifdef GREY_READER_CHECK_EN
          acc_d   = 1'b0;
`endif
        end
      end
      S_SCAN: begin
        if (wc_q != 3'd0) begin
          wc_d = wc_q - 3'd1;
        end else begin
          shadow_d[{idx_q, 2'b00} +: 4] = code_ok ? dig : BAD_DIGIT;
`ifdef GREY_READER_CHECK_EN
          if (!code_ok) acc_d = 1'b1;
`endif
          if (idx_q < LAST_IDX) begin
            idx_d = idx_q + 4'd1;
            wc_d  = LAT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Only point where the published snapshot changes.
        bcd_d   = shadow_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef GREY_READER_CHECK_EN
        err_d   = acc_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      wc_q     <= 3'd0;
      shadow_q <= 48'd0;
      bcd_q    <= 48'd0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wc_q     <= wc_d;
      shadow_q <= shadow_d;
      bcd_q    <= bcd_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

`ifdef GREY_READER_CHECK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_sel   = {4'b0000, idx_q};
  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_bcd   = bcd_q;

endmodule

// File: tb/tb_grey_reader.sv
// tb_grey_reader: drives two grey_reader instances (SEL_LAT=0 with a
//   combinational counter model, SEL_LAT=1 with a registered one) and checks
//   every cycle against a frame-timeline and Johnson-code reference model.
module tb_grey_reader;

`ifdef GREY_READER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  start_v;
  logic [7:0]  cnt0, cnt1;
  logic [7:0]  sel0, sel1;
  logic        busy0, busy1, valid0, valid1, err0, err1;
  logic [47:0] bcd0, bcd1;
  logic [2:0]  junk0, junk1;

  logic [4:0]  codes [2][12];
  bit          inject [2];

  logic [7:0]  exp_sel [2];
  logic [47:0] exp_bcd [2];
  logic        exp_err [2];

  int n_vec = 0;
  int n_bad = 0;

  grey_reader #(.SEL_LAT(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_cnt(cnt0),
    .o_sel(sel0), .o_busy(busy0), .o_valid(valid0), .o_bcd(bcd0), .o_err(err0)
  );

  grey_reader #(.SEL_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_cnt(cnt1),
    .o_sel(sel1), .o_busy(busy1), .o_valid(valid1), .o_bcd(bcd1), .o_err(err1)
  );

  // Junk on the ignored upper readout bits.
  always @(negedge clk) begin
    junk0 = 3'($urandom);
    junk1 = 3'($urandom);
  end

  // Counter for SEL_LAT=0: combinational readout.
  always_comb begin
    cnt0 = {junk0, 5'b00000};
    if (sel0[3:0] < 4'd12) cnt0[4:0] = codes[0][sel0[3:0]];
    if (inject[0] && sel0 == 8'd3) cnt0[4:0] = 5'b01010;
  end

  // Counter for SEL_LAT=1: readout registered one cycle after the select.
  always @(posedge clk) begin
    logic [4:0] c;
    c = 5'b00000;
    if (sel1[3:0] < 4'd12) c = codes[1][sel1[3:0]];
    if (inject[1] && sel1 == 8'd3) c = 5'b01010;
    cnt1 <= {junk1, c};
  end

  // Johnson code of decimal digit d: d ones filling from the LSB, then zeros
  // filling from the LSB for 6..9.
  function automatic logic [4:0] jenc(input int d);
    logic [4:0] ones;
    ones = 5'h1F;
    if (d <= 5) return ones >> (5 - d);
    return ones << (d - 5);
  endfunction

  function automatic logic [7:0]  g_sel(input int d);   return d ? sel1   : sel0;   endfunction
  function automatic logic        g_busy(input int d);  return d ? busy1  : busy0;  endfunction
  function automatic logic        g_valid(input int d); return d ? valid1 : valid0; endfunction
  function automatic logic [47:0] g_bcd(input int d);   return d ? bcd1   : bcd0;   endfunction
  function automatic logic        g_err(input int d);   return d ? err1   : err0;   endfunction

  task automatic compute_exp(input int d, output logic [47:0] b, output logic e);
    logic [4:0] c;
    int found;
    b = 48'd0;
    e = 1'b0;
    for (int n = 0; n < 12; n++) begin
      c = (inject[d] && n == 3) ? 5'b01010 : codes[d][n];
      found = -1;
      for (int v = 0; v < 10; v++) if (jenc(v) == c) found = v;
      if (found >= 0) begin
        b[4*n +: 4] = found[3:0];
      end else begin
        b[4*n +: 4] = CHK ? 4'hF : 4'h0;
        if (CHK) e = 1'b1;
      end
    end
  endtask

  task automatic set_codes_dec(input int d, input logic [47:0] v);
    for (int n = 0; n < 12; n++) codes[d][n] = jenc(int'(v[4*n +: 4]));
  endtask

  task automatic set_codes_rand(input int d, input bit allow_bad);
    for (int n = 0; n < 12; n++) begin
      if (allow_bad && $urandom_range(0, 3) == 0) codes[d][n] = 5'($urandom);
      else codes[d][n] = jenc(int'($urandom_range(0, 9)));
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      exp_sel[d] = 8'd0;
      exp_bcd[d] = 48'd0;
      exp_err[d] = 1'b0;
    end
  endtask

  task automatic check_outputs(input int d, input string name, input int t,
                               input logic eb, input logic ev);
    n_vec++;
    if (g_busy(d) !== eb) begin
      n_bad++;
      $display("FAIL %s busy d%0d t=%0d: got %b want %b", name, d, t, g_busy(d), eb);
    end
    n_vec++;
    if (g_valid(d) !== ev) begin
      n_bad++;
      $display("FAIL %s valid d%0d t=%0d: got %b want %b", name, d, t, g_valid(d), ev);
    end
    n_vec++;
    if (g_sel(d) !== exp_sel[d]) begin
      n_bad++;
      $display("FAIL %s sel d%0d t=%0d: got %0d want %0d", name, d, t, g_sel(d), exp_sel[d]);
    end
    n_vec++;
    if (g_bcd(d) !== exp_bcd[d]) begin
      n_bad++;
      $display("FAIL %s bcd d%0d t=%0d: got %h want %h", name, d, t, g_bcd(d), exp_bcd[d]);
    end
    n_vec++;
    if (g_err(d) !== exp_err[d]) begin
      n_bad++;
      $display("FAIL %s err d%0d t=%0d: got %b want %b", name, d, t, g_err(d), exp_err[d]);
    end
  endtask

  // Holds start high for edges 0..hold-1 and follows the frame timeline:
  // a frame accepted at edge s publishes after edge s+F, next accept at s+F+1.
  // Entered and left on a falling edge.
  task automatic run_frame(input int d, input int hold, input string name);
    int L, F, active, rel, nval, expv;
    logic [47:0] fb;
    logic fe, eb, ev;
    L = d ? 1 : 0;
    F = 12 * (L + 1) + 1;
    active = -1;
    nval = 0;
    expv = 0;
    compute_exp(d, fb, fe);
    start_v[d] = 1'b1;
    for (int t = 0; t < hold + F + 2; t++) begin
      @(posedge clk);
      if (active >= 0 && t == active + F + 1) active = -1;
      if (active < 0 && t < hold) active = t;
      @(negedge clk);
      if (t == hold - 1) start_v[d] = 1'b0;
      eb = 1'b0;
      ev = 1'b0;
      if (active >= 0) begin
        rel = t - active;
        eb = (rel < F);
        ev = (rel == F);
        exp_sel[d] = 8'((rel / (L + 1)) > 11 ? 11 : rel / (L + 1));
      end
      if (ev) begin
        exp_bcd[d] = fb;
        exp_err[d] = fe;
        expv++;
      end
      if (g_valid(d) === 1'b1) nval++;
      check_outputs(d, name, t, eb, ev);
    end
    n_vec++;
    if (nval != expv) begin
      n_bad++;
      $display("FAIL %s valid_count d%0d: got %0d want %0d", name, d, nval, expv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d, "reset", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_outputs(d, "idle", t, 1'b0, 1'b0);
    end
  endtask

  task automatic test_known();
    set_codes_dec(1, 48'h123456789012);
    run_frame(1, 1, "known");
  endtask

  task automatic test_nines();
    for (int n = 0; n < 12; n++) codes[0][n] = 5'b10000;
    run_frame(0, 1, "nines");
  endtask

  task automatic test_bad_code();
    for (int d = 0; d < 2; d++) begin
      set_codes_rand(d, 1'b0);
      inject[d] = 1'b1;
      run_frame(d, 1, "inject");
      inject[d] = 1'b0;
      run_frame(d, 1, "clean");
    end
  endtask

  task automatic test_hold();
    set_codes_rand(1, 1'b0);
    run_frame(1, 27, "hold1");
    set_codes_rand(0, 1'b1);
    run_frame(0, 15, "hold0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      set_codes_rand(i % 2, 1'b1);
      run_frame(i % 2, 1, "random");
    end
  endtask

  task automatic test_mid_reset();
    set_codes_rand(1, 1'b0);
    start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    check_outputs(1, "midrst_async", 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      check_outputs(1, "midrst_quiet", t, 1'b0, 1'b0);
    end
    set_codes_rand(1, 1'b1);
    run_frame(1, 1, "after_rst");
  endtask

  initial begin
    rst = 1'b1;
    start_v = 2'b00;
    for (int d = 0; d < 2; d++) begin
      inject[d] = 1'b0;
      for (int n = 0; n < 12; n++) codes[d][n] = 5'b00000;
    end
    clear_model();
    @(negedge clk);
    test_reset();
    test_known();
    test_nines();
    test_bad_code();
    test_hold();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
